mpeg_payload_buffer: RTL and testbench
======================================

// Module: mpeg_payload_buffer
// PURPOSE
//  Sits directly downstream of the MPEG demuxer. Captures only PES payload bytes
//  (mpeg_packet_body=1) into a byte FIFO and gates the FIFO output to the decoder.
//  No byte leaves until the demuxer's start time is valid and dclk has reached it.
//  Provides valid/ready output, fill level and sticky overflow for the host side.
// PARAMETERS
//  DEPTH_LOG2  11   FIFO depth = 2**DEPTH_LOG2 bytes (2048)
//  unit        ""   string prefix for $display trace lines (simulation only)
// PORTS
//  clk              in   1       system clock; all logic single-domain
//  reset_n          in   1       asynchronous, active-low reset
//  mpeg_data        in   8       byte stream, same byte the demuxer sees
//  data_valid       in   1       mpeg_data qualifier, one byte per cycle max
//  mpeg_packet_body in   1       demuxer output; 1 = current byte is payload
//  dclk             in   32      45 kHz timebase, unsigned
//  start_time       in   33      signed demuxer system_clock_reference_start_time
//  start_time_valid in   1       demuxer system_clock_reference_start_time_valid
//  flush            in   1       sync clear: empties FIFO, clears overflow, rearms gate
//  out_data         out  8       payload byte to decoder
//  out_valid        out  1       out_data holds a valid byte
//  out_ready        in   1       decoder accepts byte when out_valid&&out_ready
//  level            out  DEPTH_LOG2+1  bytes stored, incl. output register
//  overflow         out  1       sticky: a payload byte was dropped
//  playing          out  1       gate open (state PLAY)
// BEHAVIOUR
//  Reset (reset_n=0, async): FIFO empty, out_valid=0, out_data=0, level=0,
//   overflow=0, playing=0, state=WAIT_SYNC. Holding reset_n=0 mid-stream discards all data.
//  Write: data_valid && mpeg_packet_body sampled in the same cycle -> byte pushed.
//   Bytes with mpeg_packet_body=0 (pack/PES headers) are never stored.
//  Full: write when level==2**DEPTH_LOG2 at cycle start -> byte dropped, overflow<=1,
//   even if a read occurs in the same cycle. No partial/corrupt writes.
//  Storage: inferred sync-read RAM plus one output register (first-word-fall-through).
//   Latency: byte written in cycle N with FIFO empty and state PLAY -> out_valid=1
//   at cycle N+2 at the earliest.
//  Handshake: out_data/out_valid stable while out_valid && !out_ready; sustained
//   1 byte/cycle when out_ready=1 and data available. Order strictly preserved.
//  Level: +1 on accepted write, -1 on handshake, unchanged on both/neither.
//  Gate state machine:
//   WAIT_SYNC: playing=0; -> WAIT_TIME when start_time_valid=1.
//   WAIT_TIME: playing=0; -> PLAY when $signed({1'b0,dclk}) >= start_time
//     (33-bit signed compare); -> WAIT_SYNC if start_time_valid drops.
//   PLAY: playing=1; -> WAIT_SYNC if start_time_valid drops.
//  out_valid may only rise in PLAY. A byte already presented (out_valid=1) when
//   leaving PLAY stays presented until handshaken; no new byte is loaded until PLAY.
//  Writes continue in every state (pre-buffering before start time).
//  flush: synchronous, priority over write/read in the same cycle; FIFO empty,
//   out_valid=0, level=0, overflow=0, state=WAIT_SYNC next cycle.
//  Wrap-around: read/write pointers DEPTH_LOG2 bits, wrap mod depth; full/empty
//   derived from level, never from pointer equality alone.
//  $display on each state transition: "<unit> GATE <state> dclk=<n>".
// TESTING
//  1 Reset: reset_n=0 during active writes -> all outputs 0 asynchronously, level=0
//    after release, first subsequent payload byte is the first byte out.
//  2 Filtering: 00 00 01 E0 + 6 header bytes (body=0) then bytes 11..15 (body=1)
//    -> level=5, out sequence 11,12,13,14,15, no header byte ever output.
//  3 Gate: start_time=1000 valid, bytes stored, dclk ramps 990..1010 -> out_valid=0
//    until dclk=1000, playing=1 and first byte valid <=2 cycles later.
//  4 Backpressure: PLAY, 4 bytes stored, out_ready=0 for 10 cycles -> out_data stable,
//    out_valid=1; then out_ready=1 -> 4 bytes in 4 consecutive cycles, level=0.
//  5 Overflow/wrap: DEPTH+3 payload writes with out_ready=0 -> level=DEPTH,
//    overflow=1, first DEPTH bytes drained intact; repeat twice to exercise wrap.
//  6 Flush/resync: flush during PLAY with level=100 and write same cycle -> level=0,
//    overflow=0, playing=0; start_time_valid 1->0 in PLAY -> WAIT_SYNC, data retained.

Source files
------------

// File: rtl/mpeg_payload_buffer_if.sv
// Decoder-side byte stream of the payload buffer: valid/ready handshake.
// master = payload buffer (drives data/valid), slave = decoder (drives ready).
interface mpeg_payload_buffer_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/mpeg_payload_buffer.sv
// PES payload byte FIFO behind the MPEG demuxer; output gated until dclk reaches
// the demuxer start time. Sync-read RAM whose read register is the output stage.
module mpeg_payload_buffer #(
    parameter int    DEPTH_LOG2 = 11,
    parameter string unit       = ""
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               mpeg_data,
    input  logic                     data_valid,
    input  logic                     mpeg_packet_body,
    input  logic [31:0]              dclk,
    input  logic signed [32:0]       start_time,
    input  logic                     start_time_valid,
    input  logic                     flush,
    mpeg_payload_buffer_if.master    dec,
    output logic [DEPTH_LOG2:0]      level,
    output logic                     overflow,
    output logic                     playing
);
    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {WAIT_SYNC, WAIT_TIME, PLAY} gate_state_t;

    gate_state_t             state, state_nxt;
    logic [7:0]              mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]     ram_cnt;
    logic [7:0]              out_data_p1;
    logic                    out_valid_p1;
    logic                    wr_req, wr_acc, wr_drop, load, pop, time_reached;

    assign time_reached = $signed({1'b0, dclk}) >= start_time;

    always_comb begin
        state_nxt = state;
        playing   = 1'b0;
        case (state)
            WAIT_SYNC: if (start_time_valid) state_nxt = WAIT_TIME;
            WAIT_TIME: begin
                if (!start_time_valid)  state_nxt = WAIT_SYNC;
                else if (time_reached)  state_nxt = PLAY;
            end
            PLAY: begin
                playing = 1'b1;
                if (!start_time_valid) state_nxt = WAIT_SYNC;
            end
            default: state_nxt = WAIT_SYNC;
        endcase
        if (flush) state_nxt = WAIT_SYNC;
    end

    // Level counts the RAM contents plus the byte held in the output register,
    // so a full RAM can never be overwritten at the entry being read.
    assign level   = ram_cnt + {{DEPTH_LOG2{1'b0}}, out_valid_p1};
    assign wr_req  = data_valid && mpeg_packet_body && !flush;
    assign wr_acc  = wr_req && (level != FULL_LVL);
    assign wr_drop = wr_req && (level == FULL_LVL);
    assign pop     = out_valid_p1 && dec.out_ready;
    // New bytes only enter the output register while the gate is open.
    assign load    = (state == PLAY) && (ram_cnt != '0) && (!out_valid_p1 || dec.out_ready) && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= WAIT_SYNC;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            ram_cnt      <= '0;
            out_valid_p1 <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                rd_ptr       <= wr_ptr;
                ram_cnt      <= '0;
                out_valid_p1 <= 1'b0;
                overflow     <= 1'b0;
            end else begin
                if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
                if (load)   rd_ptr <= rd_ptr + 1'b1;
                case ({wr_acc, load})
                    2'b10:   ram_cnt <= ram_cnt + 1'b1;
                    2'b01:   ram_cnt <= ram_cnt - 1'b1;
                    default: ram_cnt <= ram_cnt;
                endcase
                if (load)     out_valid_p1 <= 1'b1;
                else if (pop) out_valid_p1 <= 1'b0;
                if (wr_drop)  overflow <= 1'b1;
            end
        end
    end

    // ---- stage p0: RAM write ----
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= mpeg_data;
    end

    // ---- stage p1: registered RAM read doubles as the output register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  out_data_p1 <= 8'h00;
        else if (load) out_data_p1 <= mem[rd_ptr];
    end

    assign dec.out_data  = out_data_p1;
    assign dec.out_valid = out_valid_p1;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset_n && (state_nxt != state))
            $display("%s GATE %s dclk=%0d", unit, state_nxt.name(), dclk);
    end
`endif
endmodule

// File: tb/tb_mpeg_payload_buffer.sv
// Directed bench for mpeg_payload_buffer: table-driven filtering vectors plus
// hand-written reset, gate, backpressure, overflow/wrap and flush sequences.
module tb_mpeg_payload_buffer;
    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [7:0]         mpeg_data = 8'h00;
    logic               data_valid = 1'b0;
    logic               mpeg_packet_body = 1'b0;
    logic [31:0]        dclk = 32'd0;
    logic signed [32:0] start_time = 33'sd0;
    logic               start_time_valid = 1'b0;
    logic               flush = 1'b0;
    logic [DL:0]        level;
    logic               overflow;
    logic               playing;

    mpeg_payload_buffer_if dec();

    mpeg_payload_buffer #(.DEPTH_LOG2(DL), .unit("tb")) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .mpeg_data        (mpeg_data),
        .data_valid       (data_valid),
        .mpeg_packet_body (mpeg_packet_body),
        .dclk             (dclk),
        .start_time       (start_time),
        .start_time_valid (start_time_valid),
        .flush            (flush),
        .dec              (dec),
        .level            (level),
        .overflow         (overflow),
        .playing          (playing)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        dv;
        logic        body;
        logic [7:0]  data;
        logic        rdy;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic [DL:0] exp_level;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_byte(input logic [7:0] d);
        data_valid       = 1'b1;
        mpeg_packet_body = 1'b1;
        mpeg_data        = d;
        tick();
        data_valid       = 1'b0;
        mpeg_packet_body = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int max_cycles);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (dec.out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(name, 64'(ok), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hdr [10];
        logic [7:0] base;

        hdr = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h81, 8'h80, 8'h05, 8'h21, 8'h00, 8'h01};
        for (int i = 0; i < 10; i++)
            vecs[i] = '{1'b1, 1'b0, hdr[i], 1'b0, 1'b0, 8'h00, 5'd0};
        vecs[10] = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 5'd1};
        vecs[11] = '{1'b1, 1'b1, 8'h12, 1'b0, 1'b1, 8'h11, 5'd2};
        vecs[12] = '{1'b1, 1'b1, 8'h13, 1'b0, 1'b1, 8'h11, 5'd3};
        vecs[13] = '{1'b1, 1'b1, 8'h14, 1'b0, 1'b1, 8'h11, 5'd4};
        vecs[14] = '{1'b1, 1'b1, 8'h15, 1'b0, 1'b1, 8'h11, 5'd5};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h12, 5'd4};
        vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h13, 5'd3};
        vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h14, 5'd2};
        vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h15, 5'd1};
        vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0};

        dec.out_ready    = 1'b0;
        start_time_valid = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(dec.out_valid), 64'd0);
        check("rst_out_data",  64'(dec.out_data),  64'd0);
        check("rst_level",     64'(level),         64'd0);
        check("rst_overflow",  64'(overflow),      64'd0);
        check("rst_playing",   64'(playing),       64'd0);

        // reset during active writes discards everything
        reset_n = 1'b1;
        put_byte(8'hAA);
        put_byte(8'hBB);
        put_byte(8'hCC);
        tick();
        tick();
        check("pre_rst_level", 64'(level),         64'd3);
        check("pre_rst_valid", 64'(dec.out_valid), 64'd1);
        data_valid       = 1'b1;
        mpeg_packet_body = 1'b1;
        mpeg_data        = 8'hDD;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid",   64'(dec.out_valid), 64'd0);
        check("async_rst_data",    64'(dec.out_data),  64'd0);
        check("async_rst_level",   64'(level),         64'd0);
        check("async_rst_playing", 64'(playing),       64'd0);
        @(posedge clk);
        #1;
        data_valid       = 1'b0;
        mpeg_packet_body = 1'b0;
        reset_n          = 1'b1;
        tick();
        check("post_rst_level", 64'(level), 64'd0);
        put_byte(8'h5A);
        wait_valid("post_rst_first_timeout", 10);
        check("post_rst_first_byte", 64'(dec.out_data), 64'h5A);
        dec.out_ready = 1'b1;
        tick();
        dec.out_ready = 1'b0;
        check("post_rst_drain_level", 64'(level),         64'd0);
        check("post_rst_drain_valid", 64'(dec.out_valid), 64'd0);

        // header filtering, table-driven
        for (int i = 0; i < 20; i++) begin
            data_valid       = vecs[i].dv;
            mpeg_packet_body = vecs[i].body;
            mpeg_data        = vecs[i].data;
            dec.out_ready    = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d_valid", i), 64'(dec.out_valid), 64'(vecs[i].exp_valid));
            check($sformatf("vec%0d_level", i), 64'(level),         64'(vecs[i].exp_level));
            if (vecs[i].exp_valid)
                check($sformatf("vec%0d_data", i), 64'(dec.out_data), 64'(vecs[i].exp_data));
        end
        data_valid       = 1'b0;
        mpeg_packet_body = 1'b0;
        dec.out_ready    = 1'b0;

        // start-time gate
        start_time_valid = 1'b0;
        tick();
        check("gate_resync_playing", 64'(playing), 64'd0);
        start_time       = 33'sd1000;
        dclk             = 32'd990;
        start_time_valid = 1'b1;
        put_byte(8'h31);
        put_byte(8'h32);
        put_byte(8'h33);
        for (int v = 990; v <= 1010; v++) begin
            dclk = 32'(v);
            tick();
            check($sformatf("gate_playing_%0d", v), 64'(playing),       64'(v >= 1000));
            check($sformatf("gate_valid_%0d", v),   64'(dec.out_valid), 64'(v >= 1001));
            if (v >= 1001)
                check($sformatf("gate_data_%0d", v), 64'(dec.out_data), 64'h31);
        end
        dec.out_ready = 1'b1;
        tick();
        check("gate_drain_d2", 64'(dec.out_data), 64'h32);
        tick();
        check("gate_drain_d3", 64'(dec.out_data), 64'h33);
        tick();
        check("gate_drain_valid", 64'(dec.out_valid), 64'd0);
        check("gate_drain_level", 64'(level),         64'd0);
        dec.out_ready = 1'b0;

        // backpressure
        for (int i = 0; i < 4; i++) put_byte(8'(8'h41 + i));
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("bp_hold_valid_%0d", i), 64'(dec.out_valid), 64'd1);
            check($sformatf("bp_hold_data_%0d", i),  64'(dec.out_data),  64'h41);
        end
        check("bp_level", 64'(level), 64'd4);
        dec.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_stream_valid_%0d", i), 64'(dec.out_valid), 64'd1);
            check($sformatf("bp_stream_data_%0d", i),  64'(dec.out_data),  64'(8'h41 + i));
            tick();
        end
        check("bp_end_valid", 64'(dec.out_valid), 64'd0);
        check("bp_end_level", 64'(level),         64'd0);
        dec.out_ready = 1'b0;

        // overflow and pointer wrap, two passes
        for (int pass = 0; pass < 2; pass++) begin
            base = (pass == 0) ? 8'h80 : 8'hA0;
            for (int i = 0; i < DEPTH + 3; i++) put_byte(8'(base + i));
            check($sformatf("ovf%0d_level", pass),    64'(level),         64'(DEPTH));
            check($sformatf("ovf%0d_flag", pass),     64'(overflow),      64'd1);
            check($sformatf("ovf%0d_valid", pass),    64'(dec.out_valid), 64'd1);
            dec.out_ready = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                check($sformatf("ovf%0d_drain_valid_%0d", pass, i), 64'(dec.out_valid), 64'd1);
                check($sformatf("ovf%0d_drain_data_%0d", pass, i),  64'(dec.out_data),  64'(8'(base + i)));
                tick();
            end
            dec.out_ready = 1'b0;
            check($sformatf("ovf%0d_end_level", pass), 64'(level),         64'd0);
            check($sformatf("ovf%0d_end_valid", pass), 64'(dec.out_valid), 64'd0);
        end

        // flush with a simultaneous write, then resync via start_time_valid
        for (int i = 0; i < 10; i++) put_byte(8'(8'h50 + i));
        check("pre_flush_level",    64'(level),    64'd10);
        check("pre_flush_overflow", 64'(overflow), 64'd1);
        flush            = 1'b1;
        data_valid       = 1'b1;
        mpeg_packet_body = 1'b1;
        mpeg_data        = 8'hEE;
        tick();
        flush            = 1'b0;
        data_valid       = 1'b0;
        mpeg_packet_body = 1'b0;
        check("flush_level",    64'(level),         64'd0);
        check("flush_overflow", 64'(overflow),      64'd0);
        check("flush_playing",  64'(playing),       64'd0);
        check("flush_valid",    64'(dec.out_valid), 64'd0);
        start_time = -33'sd1;
        dclk       = 32'd0;
        tick();
        check("resync_wait_time", 64'(playing), 64'd0);
        tick();
        check("resync_negative_start", 64'(playing), 64'd1);
        put_byte(8'h61);
        put_byte(8'h62);
        put_byte(8'h63);
        tick();
        check("resync_first_valid", 64'(dec.out_valid), 64'd1);
        check("resync_first_data",  64'(dec.out_data),  64'h61);
        start_time_valid = 1'b0;
        tick();
        check("drop_playing",    64'(playing),       64'd0);
        check("drop_held_valid", 64'(dec.out_valid), 64'd1);
        check("drop_held_data",  64'(dec.out_data),  64'h61);
        check("drop_level",      64'(level),         64'd3);
        dec.out_ready = 1'b1;
        tick();
        check("drop_no_reload_valid", 64'(dec.out_valid), 64'd0);
        check("drop_retained_level",  64'(level),         64'd2);
        tick();
        check("drop_still_gated", 64'(dec.out_valid), 64'd0);
        dec.out_ready    = 1'b0;
        start_time_valid = 1'b1;
        tick();
        tick();
        check("replay_playing", 64'(playing), 64'd1);
        tick();
        check("replay_valid", 64'(dec.out_valid), 64'd1);
        check("replay_data",  64'(dec.out_data),  64'h62);
        check("replay_level", 64'(level),         64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
